// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master with an address-range guard and a PREADY timeout.
// One transfer outstanding; a zero-wait transfer responds 3 cycles after grant, out-of-range 1 cycle after.
module apb_master_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ADDR_LIMIT = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,

  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic              resp0_err,

  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              resp1_err,

  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LIMIT    = ADDR_W'(ADDR_LIMIT);

  logic [1:0]       state;
  logic             last_grant;   // 1: requester 1 was served last
  logic             owner;
  logic [CNT_W-1:0] wait_cnt;

  logic              pick;
  logic              grant;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_oor;

  logic              fin;
  logic              fin_id;
  logic [DATA_W-1:0] fin_rdata;
  logic              fin_err;

  // On a tie, grant the requester that was not served last.
  assign pick      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign grant     = (state == ST_IDLE) && (req0_valid || req1_valid) && !PRESET;
  assign req0_ready = grant && !pick;
  assign req1_ready = grant && pick;

  assign sel_write = pick ? req1_write : req0_write;
  assign sel_addr  = pick ? req1_addr  : req0_addr;
  assign sel_wdata = pick ? req1_wdata : req0_wdata;
  assign sel_oor   = (sel_addr >= LIMIT);

  assign PSELx       = (state == ST_SETUP) || (state == ST_ACCESS);
  assign PENABLE     = (state == ST_ACCESS);
  assign resp0_valid = (state == ST_RESP) && !owner;
  assign resp1_valid = (state == ST_RESP) && owner;

  // Completion event: the cycle whose edge moves the FSM into RESP.
  always_comb begin
    fin       = 1'b0;
    fin_id    = owner;
    fin_rdata = '0;
    fin_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant && sel_oor) begin
          fin     = 1'b1;
          fin_id  = pick;
          fin_err = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (PREADY) begin
          fin       = 1'b1;
          fin_rdata = PWRITE ? '0 : PRDATA;
        end else if (wait_cnt == CNT_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      wait_cnt   <= '0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner <= pick;
            if (sel_oor) begin
              state <= ST_RESP;
            end else begin
              state  <= ST_SETUP;
              PWRITE <= sel_write;
              PADDR  <= sel_addr;
              PWDATA <= sel_wdata;
            end
          end
        end
        ST_SETUP: begin
          state    <= ST_ACCESS;
          wait_cnt <= '0;
        end
        ST_ACCESS: begin
          if (fin) begin
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          last_grant <= owner;
          wait_cnt   <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response data per requester holds until that requester's next response.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      resp0_rdata <= '0;
      resp0_err   <= 1'b0;
      resp1_rdata <= '0;
      resp1_err   <= 1'b0;
    end else if (fin) begin
      if (fin_id) begin
        resp1_rdata <= fin_rdata;
        resp1_err   <= fin_err;
      end else begin
        resp0_rdata <= fin_rdata;
        resp0_err   <= fin_err;
      end
    end
  end

endmodule
